// File: rtl/axi_mem_rw_arbiter.sv
// Arbitrates one memory port between the AXI read and write controllers and
// routes in-order responses back by tag. Optional ARB_STALL_CNT_EN adds stall counters.
module axi_mem_rw_arbiter #(
  parameter int MEM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH     = 64,
  parameter int BURST_MAX      = 8,
  parameter int MAX_OUTST      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_valid_i,
  input  logic [MEM_ADDR_WIDTH-1:0] rd_A_i,
  input  logic                      rd_size_i,
  output logic                      rd_grant_o,
  output logic                      rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]     rd_Q_o,
  input  logic                      wr_valid_i,
  input  logic [MEM_ADDR_WIDTH-1:0] wr_A_i,
  input  logic [DATA_WIDTH-1:0]     wr_D_i,
  input  logic [DATA_WIDTH/8-1:0]   wr_BE_i,
  input  logic                      wr_size_i,
  output logic                      wr_grant_o,
  output logic                      wr_rvalid_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic                      mem_size_o,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]               rd_stall_cnt_o,
  output logic [15:0]               wr_stall_cnt_o
`endif
);

  // state  | meaning
  // OWN_RD | read side held the port last (or nothing granted since reset)
  // OWN_WR | write side held the port last
  typedef enum logic {OWN_RD = 1'b0, OWN_WR = 1'b1} owner_t;

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int NW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] RUN_MAX  = CW'(BURST_MAX);
  localparam logic [NW-1:0] CNT_FULL = NW'(MAX_OUTST);

  owner_t          r_last, w_last_nxt;
  logic [CW-1:0]   r_run_cnt, w_run_nxt;
  logic            r_tags [MAX_OUTST];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [NW-1:0]   r_count;

  logic   w_burst_done, w_sel_wr, w_full, w_empty, w_accept, w_pop, w_head;
  owner_t w_side;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= OWN_RD;
      r_run_cnt <= '0;
    end else begin
      r_last    <= w_last_nxt;
      r_run_cnt <= w_run_nxt;
    end
  end

  always_comb begin
    w_last_nxt   = r_last;
    w_run_nxt    = r_run_cnt;
    w_burst_done = (r_run_cnt == RUN_MAX);
    // Contention keeps the current owner until its run hits the limit.
    if (rd_valid_i && wr_valid_i)
      w_sel_wr = w_burst_done ? (r_last == OWN_RD) : (r_last == OWN_WR);
    else
      w_sel_wr = wr_valid_i;
    w_side    = w_sel_wr ? OWN_WR : OWN_RD;
    w_full    = (r_count == CNT_FULL);
    w_empty   = (r_count == '0);
    mem_req_o = (rd_valid_i | wr_valid_i) & ~w_full & ~rst;
    w_accept  = mem_req_o & mem_gnt_i;
    if (w_accept) begin
      if (w_side == r_last) begin
        if (!w_burst_done) w_run_nxt = r_run_cnt + CW'(1);
      end else begin
        w_last_nxt = w_side;
        w_run_nxt  = CW'(1);
      end
    end
  end

  assign rd_grant_o  = w_accept & ~w_sel_wr;
  assign wr_grant_o  = w_accept &  w_sel_wr;
  assign mem_wen_o   = ~w_sel_wr;
  assign mem_add_o   = w_sel_wr ? wr_A_i : rd_A_i;
  assign mem_wdata_o = w_sel_wr ? wr_D_i : '0;
  assign mem_be_o    = w_sel_wr ? wr_BE_i : '1;
  assign mem_size_o  = w_sel_wr ? wr_size_i : rd_size_i;

  assign w_pop       = mem_rvalid_i & ~w_empty & ~rst;
  assign w_head      = r_tags[r_rptr];
  assign rd_rvalid_o = w_pop & ~w_head;
  assign wr_rvalid_o = w_pop &  w_head;
  assign rd_Q_o      = mem_rdata_i;

  // Pointers wrap naturally since MAX_OUTST is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_tags[r_wptr] <= w_sel_wr;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] r_rd_stall, r_wr_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_stall <= '0;
      r_wr_stall <= '0;
    end else begin
      if (rd_valid_i && !rd_grant_o && r_rd_stall != 16'hFFFF) r_rd_stall <= r_rd_stall + 16'd1;
      if (wr_valid_i && !wr_grant_o && r_wr_stall != 16'hFFFF) r_wr_stall <= r_wr_stall + 16'd1;
    end
  end

  assign rd_stall_cnt_o = r_rd_stall;
  assign wr_stall_cnt_o = r_wr_stall;
`endif

endmodule

// File: tb/tb_axi_mem_rw_arbiter.sv
// Directed and randomized bench for axi_mem_rw_arbiter against a queue-based
// model of ownership runs and outstanding response tags.
module tb_axi_mem_rw_arbiter;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int BURST_MAX = 8;
  localparam int MAX_OUTST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_valid_i = 1'b0, rd_size_i = 1'b0;
  logic [AW-1:0] rd_A_i = '0;
  logic wr_valid_i = 1'b0, wr_size_i = 1'b0;
  logic [AW-1:0] wr_A_i = '0;
  logic [DW-1:0] wr_D_i = '0;
  logic [BW-1:0] wr_BE_i = '0;
  logic mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic rd_grant_o, rd_rvalid_o, wr_grant_o, wr_rvalid_o;
  logic [DW-1:0] rd_Q_o;
  logic mem_req_o, mem_wen_o, mem_size_o;
  logic [AW-1:0] mem_add_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] rd_stall_cnt_o, wr_stall_cnt_o;
  int m_rst_cnt = 0, m_wst_cnt = 0;
`endif

  axi_mem_rw_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BURST_MAX),
                       .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .rd_valid_i(rd_valid_i), .rd_A_i(rd_A_i), .rd_size_i(rd_size_i),
    .rd_grant_o(rd_grant_o), .rd_rvalid_o(rd_rvalid_o), .rd_Q_o(rd_Q_o),
    .wr_valid_i(wr_valid_i), .wr_A_i(wr_A_i), .wr_D_i(wr_D_i), .wr_BE_i(wr_BE_i),
    .wr_size_i(wr_size_i), .wr_grant_o(wr_grant_o), .wr_rvalid_o(wr_rvalid_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_wen_o(mem_wen_o),
    .mem_add_o(mem_add_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_size_o(mem_size_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef ARB_STALL_CNT_EN
    , .rd_stall_cnt_o(rd_stall_cnt_o), .wr_stall_cnt_o(wr_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: current owner, length of its uninterrupted run, queue of issued tags (1 = write).
  int m_owner = 0;
  int m_run = 0;
  bit m_q[$];

  int n_rdg = 0, n_wrg = 0, n_rdv = 0, n_wrv = 0, n_req_low = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_rdg = 0; n_wrg = 0; n_rdv = 0; n_wrv = 0; n_req_low = 0;
  endtask

  task automatic cyc();
    bit full, exp_req, winner, acc, pop, head;
    @(negedge clk);
    #1;
    full    = (m_q.size() >= MAX_OUTST);
    exp_req = (rd_valid_i || wr_valid_i) && !full && !rst;
    if (rd_valid_i && wr_valid_i)
      winner = (m_run >= BURST_MAX) ? bit'(m_owner == 0) : bit'(m_owner == 1);
    else
      winner = wr_valid_i;
    acc  = exp_req && mem_gnt_i;
    pop  = mem_rvalid_i && (m_q.size() > 0) && !rst;
    head = (m_q.size() > 0) ? m_q[0] : 1'b0;

    chk("mem_req",   64'(mem_req_o),   64'(exp_req));
    chk("rd_grant",  64'(rd_grant_o),  64'(acc && !winner));
    chk("wr_grant",  64'(wr_grant_o),  64'(acc && winner));
    chk("rd_rvalid", 64'(rd_rvalid_o), 64'(pop && !head));
    chk("wr_rvalid", 64'(wr_rvalid_o), 64'(pop && head));
    chk("mem_wen",   64'(mem_wen_o),   64'(!winner));
    chk("mem_add",   64'(mem_add_o),   winner ? 64'(wr_A_i) : 64'(rd_A_i));
    chk("mem_wdata", 64'(mem_wdata_o), winner ? 64'(wr_D_i) : 64'd0);
    chk("mem_be",    64'(mem_be_o),    winner ? 64'(wr_BE_i) : 64'hFF);
    chk("mem_size",  64'(mem_size_o),  winner ? 64'(wr_size_i) : 64'(rd_size_i));
    chk("rd_Q",      64'(rd_Q_o),      64'(mem_rdata_i));
`ifdef ARB_STALL_CNT_EN
    chk("rd_stall", 64'(rd_stall_cnt_o), 64'(m_rst_cnt));
    chk("wr_stall", 64'(wr_stall_cnt_o), 64'(m_wst_cnt));
`endif
    n_rdg += int'(rd_grant_o);
    n_wrg += int'(wr_grant_o);
    n_rdv += int'(rd_rvalid_o);
    n_wrv += int'(wr_rvalid_o);
    n_req_low += int'(!mem_req_o);

    @(posedge clk);
    if (rst) begin
      m_owner = 0; m_run = 0; m_q.delete();
`ifdef ARB_STALL_CNT_EN
      m_rst_cnt = 0; m_wst_cnt = 0;
`endif
    end else begin
`ifdef ARB_STALL_CNT_EN
      if (rd_valid_i && !(acc && !winner) && m_rst_cnt < 65535) m_rst_cnt++;
      if (wr_valid_i && !(acc && winner) && m_wst_cnt < 65535) m_wst_cnt++;
`endif
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(winner);
        if (int'(winner) == m_owner) m_run = (m_run + 1 > BURST_MAX) ? BURST_MAX : m_run + 1;
        else begin m_owner = int'(winner); m_run = 1; end
      end
    end
    #1;
  endtask

  task automatic set_in(input bit rv, input bit wv, input bit g, input bit rvl);
    rd_valid_i = rv; wr_valid_i = wv; mem_gnt_i = g; mem_rvalid_i = rvl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rd_A_i = 13'h0123; wr_A_i = 13'h1ABC; wr_D_i = 64'hDEAD_BEEF_0BAD_F00D;
    wr_BE_i = 8'h5A; rd_size_i = 1'b1; wr_size_i = 1'b0;
    mem_rdata_i = 64'h1111_2222_3333_4444;

    // Reset state, including rvalid/valid held high under reset.
    rst = 1'b1;
    set_in(1, 1, 1, 1);
    cyc(); cyc();
    rst = 1'b0;

    // T1: read only, three requests, responses one cycle later.
    do_reset(); clr_counts();
    set_in(1, 0, 1, 0); cyc();
    set_in(1, 0, 1, 1); cyc();
    set_in(1, 0, 1, 1); cyc();
    set_in(0, 0, 1, 1); cyc();
    set_in(0, 0, 0, 0); cyc();
    chk("t1_rd_grants", 64'(n_rdg), 64'd3);
    chk("t1_rd_rvalid", 64'(n_rdv), 64'd3);
    chk("t1_wr_rvalid", 64'(n_wrv), 64'd0);

    // T2: both sides valid continuously -> RD x8, WR x8, RD x8.
    do_reset(); clr_counts();
    set_in(1, 1, 1, 1);
    for (int i = 0; i < 8; i++) cyc();
    chk("t2_rd_first8", 64'(n_rdg), 64'd8);
    chk("t2_wr_first8", 64'(n_wrg), 64'd0);
    for (int i = 0; i < 8; i++) cyc();
    chk("t2_wr_second8", 64'(n_wrg), 64'd8);
    chk("t2_rd_second8", 64'(n_rdg), 64'd8);
    for (int i = 0; i < 8; i++) cyc();
    chk("t2_rd_third8", 64'(n_rdg), 64'd16);
    chk("t2_wr_third8", 64'(n_wrg), 64'd8);

    // T3: FIFO fills after four accepts; a pop unblocks only on the next cycle.
    do_reset(); clr_counts();
    set_in(1, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc();
    chk("t3_accepts_full", 64'(n_rdg), 64'd4);
    chk("t3_req_low", 64'(n_req_low), 64'd2);
    set_in(1, 0, 1, 1); cyc();
    chk("t3_still_blocked", 64'(n_rdg), 64'd4);
    set_in(1, 0, 1, 0); cyc();
    chk("t3_resumed", 64'(n_rdg), 64'd5);

    // T4: W, R, W accepts then three in-order responses.
    do_reset(); clr_counts();
    set_in(0, 1, 1, 0); cyc();
    set_in(1, 0, 1, 0); cyc();
    set_in(0, 1, 1, 0); cyc();
    set_in(0, 0, 0, 1);
    mem_rdata_i = 64'hA5A5_0000_FFFF_1234; cyc();
    mem_rdata_i = 64'h0F0F_CAFE_BABE_7777; cyc();
    mem_rdata_i = 64'h9999_8888_7777_6666; cyc();
    set_in(0, 0, 0, 0); cyc();
    chk("t4_wr_rvalid", 64'(n_wrv), 64'd2);
    chk("t4_rd_rvalid", 64'(n_rdv), 64'd1);

    // T5: rvalid with nothing outstanding, then reset with two outstanding.
    do_reset(); clr_counts();
    set_in(0, 0, 0, 1); cyc(); cyc();
    set_in(1, 0, 1, 0); cyc(); cyc();
    rst = 1'b1; set_in(0, 0, 0, 1); cyc();
    rst = 1'b0; cyc(); cyc(); cyc();
    set_in(0, 0, 0, 0); cyc();
    chk("t5_rd_rvalid", 64'(n_rdv), 64'd0);
    chk("t5_wr_rvalid", 64'(n_wrv), 64'd0);

`ifdef ARB_STALL_CNT_EN
    // T6: write waits behind an eight-grant read run.
    do_reset(); clr_counts();
    set_in(1, 1, 1, 1);
    for (int i = 0; i < 8; i++) cyc();
    chk("t6_wr_stall8", 64'(wr_stall_cnt_o), 64'd8);
    for (int i = 0; i < 12; i++) cyc();
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      rd_valid_i   = ($urandom_range(0, 3) != 0);
      wr_valid_i   = ($urandom_range(0, 2) != 0);
      mem_gnt_i    = ($urandom_range(0, 4) != 0);
      mem_rvalid_i = ($urandom_range(0, 2) != 0);
      rd_A_i       = AW'($urandom);
      wr_A_i       = AW'($urandom);
      rd_size_i    = 1'($urandom);
      wr_size_i    = 1'($urandom);
      wr_D_i       = {$urandom, $urandom};
      wr_BE_i      = BW'($urandom);
      mem_rdata_i  = {$urandom, $urandom};
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
